// File: rtl/adc_readout_arbiter_pkg.sv
// adc_readout_arbiter_pkg: shared readout config, arbiter state type and header magic
package adc_readout_arbiter_pkg;
  localparam int PS_AXIS_WIDTH = 32;
  localparam int ADC_BUFFER_FLUSH = 4;
  localparam logic [7:0] ADC_ARB_HDR_MAGIC = 8'hA5;
  typedef enum logic [1:0] {IDLE, HEADER, GRANT, FLUSH} arb_state_t;
endpackage

// File: rtl/adc_readout_arbiter_if.sv
// adc_readout_arbiter_if: per-channel capture streams in, merged PS stream out
interface adc_readout_arbiter_if import adc_readout_arbiter_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = PS_AXIS_WIDTH
);
  localparam int IW = $clog2(NUM_CH);
  logic [NUM_CH*DATA_W-1:0] s_axis_tdata;
  logic [NUM_CH-1:0] s_axis_tvalid;
  logic [NUM_CH-1:0] s_axis_tlast;
  logic [NUM_CH-1:0] s_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic m_axis_tvalid;
  logic m_axis_tlast;
  logic [IW-1:0] m_axis_tid;
  logic m_axis_tready;
  modport master (
    input s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
  );
  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
  );
endinterface

// File: rtl/adc_readout_arbiter_skid.sv
// axis_skid_buffer: two-entry AXI-Stream register slice with registered ready
module axis_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  logic [W-1:0] sk_data;
  logic sk_valid;
  assign in_ready = !sk_valid;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      out_valid <= 1'b0;
      out_data <= '0;
      sk_valid <= 1'b0;
      sk_data <= '0;
    end else if (out_ready || !out_valid) begin
      out_valid <= sk_valid || in_valid;
      out_data <= sk_valid ? sk_data : in_data;
      sk_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      sk_valid <= 1'b1;
      sk_data <= in_data;
    end
  end
endmodule

// File: rtl/adc_readout_arbiter.sv
// adc_readout_arbiter: round-robin burst arbiter merging NUM_CH ADC capture streams onto one PS stream
// Define ADC_ARB_HEADER_EN to prefix every burst with an {A5, id, seq} header beat.
module adc_readout_arbiter import adc_readout_arbiter_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = PS_AXIS_WIDTH,
  parameter int BURST_LEN = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          gpio_ctrl,
  input  logic [NUM_CH-1:0]    ch_enable,
  adc_readout_arbiter_if.master bus,
  output logic                 busy
);
  localparam int IW = $clog2(NUM_CH);
  localparam int CW = $clog2(BURST_LEN);
  arb_state_t state, nxt;
  logic [IW-1:0] g, ptr;
  logic [CW-1:0] cnt;
  logic [IW:0] pick;
  logic flush, acc, last, in_valid, in_ready;
  logic [DATA_W-1:0] in_tdata;
  logic [DATA_W+IW:0] out_w;
  function automatic logic [IW:0] rr_pick(input logic [IW-1:0] p, input logic [NUM_CH-1:0] r);
    rr_pick = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      int k;
      k = (int'(p) + i) % NUM_CH;
      if (r[k]) rr_pick = {1'b1, IW'(k)};
    end
  endfunction
  assign flush = gpio_ctrl[ADC_BUFFER_FLUSH];
  assign pick = rr_pick(ptr, ch_enable & bus.s_axis_tvalid);
  assign last = bus.s_axis_tlast[g] || cnt == CW'(BURST_LEN - 1);
  assign acc = state == GRANT && bus.s_axis_tvalid[g] && in_ready && !flush;
  assign bus.s_axis_tready = state == FLUSH ? '1 : (state == GRANT && in_ready) ? NUM_CH'(1) << g : '0;
  assign busy = state == GRANT || state == HEADER || bus.m_axis_tvalid;
  assign {bus.m_axis_tdata, bus.m_axis_tid, bus.m_axis_tlast} = out_w;
`ifdef ADC_ARB_HEADER_EN
  localparam arb_state_t START = HEADER;
  logic [15:0] seq [NUM_CH];
  logic [DATA_W-1:0] hdr;
  always_comb begin
    hdr = '0;
    hdr[DATA_W-1:24] = (DATA_W-24)'(ADC_ARB_HDR_MAGIC);
    hdr[23:16] = 8'(g);
    hdr[15:0] = seq[g];
  end
  assign in_tdata = state == HEADER ? hdr : bus.s_axis_tdata[g*DATA_W +: DATA_W];
  // Sequence numbers count completed bursts only; flush leaves them alone.
  always_ff @(posedge clk) begin
    if (rst) seq <= '{default: '0};
    else if (acc && last) seq[g] <= seq[g] + 16'd1;
  end
`else
  localparam arb_state_t START = GRANT;
  assign in_tdata = bus.s_axis_tdata[g*DATA_W +: DATA_W];
`endif
  always_comb begin
    nxt = state;
    in_valid = 1'b0;
    case (state)
      IDLE: nxt = pick[IW] ? START : IDLE;
      HEADER: begin
        in_valid = 1'b1;
        nxt = in_ready ? GRANT : HEADER;
      end
      GRANT: begin
        in_valid = bus.s_axis_tvalid[g];
        nxt = (acc && last) ? IDLE : GRANT;
      end
      FLUSH: nxt = flush ? FLUSH : IDLE;
      default: nxt = IDLE;
    endcase
    if (flush) nxt = FLUSH;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      g <= '0;
      ptr <= '0;
      cnt <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && pick[IW]) begin
        g <= pick[IW-1:0];
        cnt <= '0;
      end
      if (acc) cnt <= cnt + CW'(1);
      if (acc && last) begin
        ptr <= g;
        cnt <= '0;
      end
      if (flush) cnt <= '0;
    end
  end
  axis_skid_buffer #(.W(DATA_W+IW+1)) u_skid (
    .clk(clk),
    .rst(rst),
    .clr(flush),
    .in_data({in_tdata, g, state == GRANT && last}),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_w),
    .out_valid(bus.m_axis_tvalid),
    .out_ready(bus.m_axis_tready)
  );
endmodule

// File: tb/tb_adc_readout_arbiter.sv
// tb_adc_readout_arbiter: randomized and directed checks against a burst-level scoreboard model
module tb_adc_readout_arbiter;
  import adc_readout_arbiter_pkg::*;
  localparam int N = 4, DW = 32, BL = 4;
  typedef struct packed {logic [DW-1:0] d; logic l;} beat_t;
  logic clk = 0, rst = 1;
  logic [15:0] gpio_ctrl = '0;
  logic [N-1:0] ch_enable = '1;
  logic busy;
  adc_readout_arbiter_if #(.NUM_CH(N), .DATA_W(DW)) bus();
  adc_readout_arbiter #(.NUM_CH(N), .DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .gpio_ctrl(gpio_ctrl), .ch_enable(ch_enable), .bus(bus), .busy(busy)
  );
  always #5 clk = ~clk;
  beat_t src_q[N][$];
  beat_t exp_q[N][$];
  int total = 0, bad = 0, cyc = 0;
  bit vrand = 0, rrand = 0, order_chk = 0, gap_chk = 0;
  logic [N-1:0] order_mask = '0;
  bit sn_m = 0;
  logic [N-1:0] sn_s = '0;
  beat_t sn_b[N];
  logic [DW-1:0] sn_d = '0;
  logic [1:0] sn_id = '0;
  logic sn_l = 0;
  int sn_cyc = 0;
  int ptr_m = 0, cur = 0, out_cnt = 0, last_end = 0, n_last = 0, n_out = 0;
  bit open_b = 0, hdr_done = 0;
  logic [15:0] seq_m[N];
  bit pv = 0;
  logic [DW+2:0] pw = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr(input int p, input logic [N-1:0] m);
    for (int k = 1; k <= N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic out_beat();
    int c = int'(sn_id);
    if (!open_b) begin
      if (order_chk) chk("grant_order", 64'(c), 64'(rr(ptr_m, order_mask)));
      if (gap_chk && n_last > 0) chk("bubble", 64'(sn_cyc - last_end), 2);
      open_b = 1; cur = c; out_cnt = 0; hdr_done = 0;
    end else chk("tid", 64'(c), 64'(cur));
`ifdef ADC_ARB_HEADER_EN
    if (!hdr_done) begin
      chk("hdr_data", 64'(sn_d), 64'({8'hA5, 8'(c), seq_m[c]}));
      chk("hdr_last", 64'(sn_l), 0);
      hdr_done = 1;
      return;
    end
`endif
    chk("beat_avail", 64'(exp_q[c].size() > 0), 1);
    if (exp_q[c].size() > 0) begin
      beat_t e = exp_q[c].pop_front();
      chk("data", 64'(sn_d), 64'(e.d));
      chk("last", 64'(sn_l), 64'(e.l || out_cnt == BL - 1));
    end
    out_cnt++; n_out++;
    if (sn_l) begin
      open_b = 0; ptr_m = c; last_end = sn_cyc; n_last++; seq_m[c]++;
    end
  endtask

  task automatic process();
    bit fl = gpio_ctrl[ADC_BUFFER_FLUSH];
    if (sn_m && !rst) out_beat();
    if (rst || fl) begin
      for (int c = 0; c < N; c++) exp_q[c].delete();
      open_b = 0; pv = 0;
    end
    if (rst) begin
      ptr_m = 0;
      for (int c = 0; c < N; c++) seq_m[c] = '0;
    end
    for (int c = 0; c < N; c++) if (sn_s[c]) begin
      if (!rst && !fl) exp_q[c].push_back(sn_b[c]);
      if (src_q[c].size() > 0) void'(src_q[c].pop_front());
    end
  endtask

  task automatic drive();
    for (int c = 0; c < N; c++) begin
      bit has = src_q[c].size() > 0;
      bus.s_axis_tvalid[c] = has && (!vrand || $urandom_range(3) != 0);
      bus.s_axis_tdata[c*DW +: DW] = has ? src_q[c][0].d : '0;
      bus.s_axis_tlast[c] = has ? src_q[c][0].l : 1'b0;
    end
    bus.m_axis_tready = rrand ? 1'($urandom_range(1)) : 1'b1;
  endtask

  task automatic capture();
    cyc++;
    if (pv) begin
      chk("hold_valid", 64'(bus.m_axis_tvalid), 1);
      chk("hold_beat", 64'({bus.m_axis_tdata, bus.m_axis_tid, bus.m_axis_tlast}), 64'(pw));
    end
    pv = bus.m_axis_tvalid && !bus.m_axis_tready;
    pw = {bus.m_axis_tdata, bus.m_axis_tid, bus.m_axis_tlast};
    if (bus.m_axis_tvalid) chk("busy", 64'(busy), 1);
    sn_m = bus.m_axis_tvalid && bus.m_axis_tready;
    sn_d = bus.m_axis_tdata; sn_id = bus.m_axis_tid; sn_l = bus.m_axis_tlast; sn_cyc = cyc;
    sn_s = bus.s_axis_tvalid & bus.s_axis_tready;
    for (int c = 0; c < N; c++) sn_b[c] = {bus.s_axis_tdata[c*DW +: DW], bus.s_axis_tlast[c]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    process();
    drive();
    @(negedge clk);
    capture();
  endtask

  task automatic load(input int c, input int n, input bit rnd_last);
    for (int i = 0; i < n; i++)
      src_q[c].push_back({DW'($urandom), (i == n - 1) || (rnd_last && $urandom_range(7) == 0)});
  endtask

  function automatic bit pending();
    if (bus.m_axis_tvalid) return 1;
    for (int c = 0; c < N; c++) if (exp_q[c].size() > 0 || (src_q[c].size() > 0 && ch_enable[c])) return 1;
    return 0;
  endfunction

  task automatic drain(input int budget);
    int i = 0;
    while (pending() && i < budget) begin step(); i++; end
    chk("drain_timeout", 64'(i < budget), 1);
  endtask

  task automatic do_reset();
    rst = 1;
    for (int c = 0; c < N; c++) src_q[c].delete();
    step(); step();
    chk("rst_tvalid", 64'(bus.m_axis_tvalid), 0);
    chk("rst_tlast", 64'(bus.m_axis_tlast), 0);
    chk("rst_tid", 64'(bus.m_axis_tid), 0);
    chk("rst_tready", 64'(bus.s_axis_tready), 0);
    chk("rst_busy", 64'(busy), 0);
    rst = 0; gpio_ctrl = '0; ch_enable = '1;
    vrand = 0; rrand = 0; order_chk = 0; gap_chk = 0;
    n_last = 0; n_out = 0; last_end = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int i;
    bus.s_axis_tvalid = '0; bus.s_axis_tdata = '0; bus.s_axis_tlast = '0; bus.m_axis_tready = 1'b1;
    for (int c = 0; c < N; c++) begin seq_m[c] = '0; sn_b[c] = '0; end
    do_reset();
    gap_chk = 1;
    load(1, 10, 0);
    drain(200);
    chk("t1_bursts", 64'(n_last), 3);
    chk("t1_beats", 64'(n_out), 10);
    do_reset();
    order_chk = 1; order_mask = '1;
    for (int c = 0; c < N; c++) load(c, 16, 0);
    drain(400);
    chk("t2_bursts", 64'(n_last), 16);
    do_reset();
    vrand = 1; rrand = 1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < N; c++) load(c, $urandom_range(20), 1);
      drain(3000);
    end
    do_reset();
    load(2, 20, 0);
    i = 0;
    while (n_out == 0 && i < 50) begin step(); i++; end
    chk("t4_start", 64'(n_out > 0), 1);
    gpio_ctrl[ADC_BUFFER_FLUSH] = 1'b1;
    step();
    chk("flush_tvalid", 64'(bus.m_axis_tvalid), 0);
    chk("flush_tready0", 64'(bus.s_axis_tready), 64'hF);
    src_q[2].delete();
    step();
    chk("flush_tready1", 64'(bus.s_axis_tready), 64'hF);
    step();
    chk("flush_tready2", 64'(bus.s_axis_tready), 64'hF);
    gpio_ctrl[ADC_BUFFER_FLUSH] = 1'b0;
    order_chk = 1; order_mask = 4'b1000; n_last = 0;
    load(3, 8, 0);
    drain(200);
    chk("t4_ch3_bursts", 64'(n_last), 2);
    do_reset();
    ch_enable = 4'b0101; order_chk = 1; order_mask = 4'b0101;
    for (int c = 0; c < N; c++) load(c, 16, 0);
    drain(400);
    chk("t5_bursts", 64'(n_last), 8);
    src_q[1].delete(); src_q[3].delete();
    do_reset();
    load(0, 10, 0);
    repeat (3) step();
    rst = 1;
    step();
    chk("rst_mid_tvalid", 64'(bus.m_axis_tvalid), 0);
    chk("rst_mid_tlast", 64'(bus.m_axis_tlast), 0);
    rst = 0;
    drain(200);
`ifdef ADC_ARB_HEADER_EN
    do_reset();
    load(0, 12, 0);
    drain(200);
    chk("hdr_bursts", 64'(n_last), 3);
    chk("hdr_seq0", 64'(seq_m[0]), 3);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adc_readout_arbiter.md
Name: adc_readout_arbiter

Overview:
- Shares the single PL-to-PS readout stream between NUM_CH ADC capture channels.
- Each channel presents its drained capture data as an AXI-Stream.
- The arbiter grants channels round-robin in bursts and tags each burst with its channel id and tlast.
- Sits between the per-channel ADC capture paths and the PS DMA stream.

Parameters:
- NUM_CH, 4, number of ADC channels sharing the readout stream.
- DATA_W, ps_axis_width, stream data width.
- BURST_LEN, 256, maximum beats per grant (must be ≥2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous to clk, active-high.
- gpio_ctrl  in  16  registered control word; bit adc_buffer_flush forces flush.
- ch_enable  in  NUM_CH  per-channel arbitration enable mask.
- s_axis_tdata  in  NUM_CH*DATA_W  channel data, channel i at bits [i*DATA_W +: DATA_W].
- s_axis_tvalid  in  NUM_CH  per-channel valid.
- s_axis_tlast  in  NUM_CH  per-channel end-of-capture marker.
- s_axis_tready  out  NUM_CH  per-channel ready.
- m_axis_tdata  out  DATA_W  merged output data.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  final beat of a burst.
- m_axis_tid  out  $clog2(NUM_CH)  source channel of the current beat.
- m_axis_tready  in  1  PS ready.
- busy  out  1  high while a grant is active.

Behaviour:
- Reset values:
  - All outputs 0 (m_axis_tvalid, m_axis_tlast, m_axis_tid, s_axis_tready, busy).
  - Round-robin pointer 0; beat counter 0; state IDLE.
- Output stage: two-entry skid buffer.
  - Input beat to m_axis_tvalid latency is 1 cycle.
  - m_axis_tvalid, once high, holds with stable tdata/tlast/tid until m_axis_tready.
  - s_axis_tready[g] is registered-ready of the skid buffer, gated to the granted channel only.
  - All other channels' s_axis_tready are 0.
- States:
  - IDLE:
    - Scan channels starting at pointer+1 mod NUM_CH.
    - Select the first channel with ch_enable=1 and s_axis_tvalid=1.
    - Go to GRANT, latch g, clear the beat counter.
    - No eligible channel: stay in IDLE.
  - GRANT:
    - Each accepted input beat (s_axis_tvalid[g] & s_axis_tready[g]) increments the counter.
    - Burst ends on the beat where counter==BURST_LEN-1 or s_axis_tlast[g]=1. That beat is forwarded with m_axis_tlast=1.
    - At burst end: pointer<=g, go to IDLE.
    - s_axis_tvalid[g] low mid-burst: hold grant and wait; no timeout.
    - ch_enable[g] dropping mid-burst has no effect until the burst ends.
  - FLUSH:
    - Entered from any state when gpio_ctrl[adc_buffer_flush]=1.
    - s_axis_tready all 1 (inputs drained and discarded); skid buffer cleared; m_axis_tvalid=0; beat counter cleared.
    - The pointer is preserved.
    - Returns to IDLE the cycle after the flush bit clears.
    - A burst interrupted by flush gets no tlast.
- IDLE-to-GRANT costs one cycle, so back-to-back bursts have a 1-cycle bubble.
- busy=1 in GRANT, and while the skid buffer holds data.
- Simultaneous requests: the lowest index after the pointer (mod NUM_CH) wins, so every channel with continuous valid is served within NUM_CH grants.
- Reset mid-burst: immediate return to reset values. Partial output is lost; no tlast is emitted.

Optional Feature:
- Macro: ADC_ARB_HEADER_EN.
- Defined:
  - Each burst is preceded by one header beat.
  - Header layout: [DATA_W-1:24] 8'hA5, [23:16] channel id, [15:0] per-channel 16-bit burst sequence number.
  - The sequence number increments after each completed burst, wraps at 16'hFFFF, is cleared by rst, and is untouched by flush.
  - Header beat has tlast=0 and the data tid.
  - The header does not count toward BURST_LEN.
  - Adds a HEADER state between IDLE and GRANT.
- Undefined:
  - No header, no sequence counters, no HEADER state.
  - Output carries raw data only.

Decomposition:
- In rfsoc_config:
  - adc_buffer_flush bit index and ps_axis_width (both already there).
  - New arb_state_t enum: IDLE, HEADER, GRANT, FLUSH.
  - ADC_ARB_HDR_MAGIC = 8'hA5.
- One sub-module: axis_skid_buffer (DATA_W+tid+tlast wide), reusable elsewhere.
- Round-robin selection is a function inside the arbiter.

Test Plan:
- Ch1 only valid, BURST_LEN=4, 10-beat capture ending in tlast, m_axis_tready=1 → bursts of 4,4,2 beats, tid=1, tlast on beats 4, 8 and 10, one idle cycle between bursts.
- All 4 channels continuously valid, BURST_LEN=4 → grant order 1,2,3,0,1…; each burst exactly 4 beats with matching tid.
- m_axis_tready toggled with random 50% duty → output sequence equals input sequence per channel; no drop or duplicate; tdata stable while tvalid & !tready.
- Flush asserted for 3 cycles mid-burst on ch2 → m_axis_tvalid=0 the cycle after assertion, all s_axis_tready=1 during flush; next grant goes to ch3.
- ch_enable=4'b0101, all channels valid → only tid 0 and 2 appear, alternating.
- With ADC_ARB_HEADER_EN, ch0 issues 3 bursts → headers 32'hA500_0000, 32'hA500_0001, 32'hA500_0002, each followed by data beats.
